ysyx_23060187_alu_arbiter: RTL

//   Shares one combinational ALU (AND/OR/ADD/SUB, 4-bit op code) between two requesters
//   (port 0: EXU, port 1: LSU address/branch helper) using valid/ready handshakes.

---
 rtl/ysyx_23060187_alu_arbiter_pkg.sv | 18 +
 rtl/ysyx_23060187_alu_arbiter_rr_arb2.sv | 19 +
 rtl/ysyx_23060187_alu_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ysyx_23060187_alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: op codes, FSM states, defaults.
package ysyx_23060187_alu_arbiter_pkg;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned CTRL_W_DEFAULT = 4;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_23060187_alu_arbiter_rr_arb2.sv
// Two-input round-robin grant: one-hot grant among valid requests, zero when idle.
module ysyx_23060187_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    // prio_i names the port that wins a tie; a lone request always wins
    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_i ? 2'b10 : 2'b01;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_23060187_alu_arbiter.sv
// Shares one external ALU between EXU (port 0) and LSU helper (port 1) with
// round-robin arbitration, one operation in flight and a held registered result.
module ysyx_23060187_alu_arbiter
    import ysyx_23060187_alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [XLEN-1:0]   req0_a,
    input  logic [XLEN-1:0]   req0_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [XLEN-1:0]   resp0_result,
    output logic              resp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [XLEN-1:0]   req1_a,
    input  logic [XLEN-1:0]   req1_b,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [XLEN-1:0]   resp1_result,
    output logic              resp1_zero,

    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]   alu_op1,
    output logic [XLEN-1:0]   alu_op2,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_zero
);

    arb_state_e        state_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              owner_q;
    logic              prio_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic              resp0_valid_q;
    logic              resp1_valid_q;

    logic [1:0]        gnt;
    logic              owner_ready;

    ysyx_23060187_rr_arb2 u_rr_arb2 (
        .req_i  ({req1_valid, req0_valid}),
        .prio_i (prio_q),
        .gnt_o  (gnt)
    );

    assign req0_ready  = (state_q == ST_IDLE) & gnt[0];
    assign req1_ready  = (state_q == ST_IDLE) & gnt[1];
    assign owner_ready = owner_q ? resp1_ready : resp0_ready;

    assign alu_ctrl = ctrl_q;
    assign alu_op1  = a_q;
    assign alu_op2  = b_q;

    assign resp0_valid  = resp0_valid_q;
    assign resp1_valid  = resp1_valid_q;
    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign resp0_zero   = zero_q;
    assign resp1_zero   = zero_q;

    // prio_q holds the tie winner (the port not served last); reset favours port 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ctrl_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            owner_q       <= 1'b0;
            prio_q        <= 1'b0;
            result_q      <= '0;
            zero_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt[1]) begin
                        ctrl_q  <= req1_ctrl;
                        a_q     <= req1_a;
                        b_q     <= req1_b;
                        owner_q <= 1'b1;
                        prio_q  <= 1'b0;
                        state_q <= ST_EXEC;
                    end else if (gnt[0]) begin
                        ctrl_q  <= req0_ctrl;
                        a_q     <= req0_a;
                        b_q     <= req0_b;
                        owner_q <= 1'b0;
                        prio_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q      <= alu_result;
                    zero_q        <= alu_zero;
                    resp0_valid_q <= ~owner_q;
                    resp1_valid_q <= owner_q;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_ready) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
